// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   UART transmitter with an input FIFO. Words arrive on a valid/ready
//   handshake and are buffered in a FIFO_DEPTH-entry FIFO. They are sent
//   LSB-first on tx_pin, with no idle gap between consecutive frames.
//
//   Frame: start, BIT data bits, optional parity, STOP_BITS stop bits.
//   Each bit lasts div clocks:
//     div = cfg_div, or CLK_FREQ/BAUD_RATE when cfg_div is 0.
//   div is latched when a word is loaded, so it stays fixed for that frame.
//
//   Optional feature: define UART_TX_PARITY_EN to insert a parity bit.
//     cfg_parity_odd = 0 selects even parity, 1 selects odd parity.
//   Without the macro, cfg_parity_odd is ignored.
//
// Ports
//   clk            system clock, posedge
//   rst            synchronous reset, active-high
//   tx_data        word to send (BIT bits)
//   tx_data_valid  tx_data is valid
//   tx_data_ready  FIFO can accept; a write happens when valid && ready
//   cfg_div        clocks per bit; 0 selects the default divisor
//   cfg_parity_odd parity sense (only used with UART_TX_PARITY_EN)
//   tx_pin         serial output, idle high
//   tx_busy        serialiser is not idle
//   fifo_level     number of words currently buffered
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 20000000,
  parameter int BAUD_RATE  = 57600,
  parameter int BIT        = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [BIT-1:0]                tx_data,
  input  logic                          tx_data_valid,
  output logic                          tx_data_ready,
  input  logic [15:0]                   cfg_div,
  input  logic                          cfg_parity_odd,
  output logic                          tx_pin,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int LW      = AW + 1;
  localparam int DEF_DIV = CLK_FREQ / BAUD_RATE;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t         state;
  logic [BIT-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [LW-1:0]  level;
  logic [BIT-1:0] shreg;
  logic [15:0]    div_q;
  logic [16:0]    cnt;
  logic [3:0]     bit_idx;
  logic           push;
  logic           pop;
  logic           bit_end;
  logic           stop_end;
  logic [15:0]    div_eff;
  logic [16:0]    stop_len;

`ifdef UART_TX_PARITY_EN
  logic           par_q;
`else
  logic           unused_parity_odd;
  assign unused_parity_odd = cfg_parity_odd;
`endif

  assign tx_data_ready = !rst && (level != LW'(FIFO_DEPTH));
  assign push          = tx_data_valid && tx_data_ready;
  assign div_eff       = (cfg_div == 16'd0) ? 16'(DEF_DIV) : cfg_div;

  // The counter is one bit wider than div so that two stop bits
  // (2*div clocks) can be counted in one stretch.
  assign bit_end  = (cnt == ({1'b0, div_q} - 17'd1));
  assign stop_len = (STOP_BITS == 2) ? {div_q, 1'b0} : {1'b0, div_q};
  assign stop_end = (cnt == (stop_len - 17'd1));

  // A word is loaded from IDLE, or on the last stop cycle for
  // back-to-back frames.
  assign pop = !rst && (level != '0) &&
               ((state == IDLE) || ((state == STOP) && stop_end));

  assign tx_busy    = (state != IDLE);
  assign fifo_level = level;

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  // FIFO pointers and level; power-of-two depth makes pointer wrap free
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Frame data: word, bit period and parity latched at load
  always_ff @(posedge clk) begin
    if (pop) begin
      shreg <= mem[rd_ptr];
      div_q <= div_eff;
`ifdef UART_TX_PARITY_EN
      par_q <= (^mem[rd_ptr]) ^ cfg_parity_odd;
`endif
    end else if ((state == DATA) && bit_end) begin
      shreg <= shreg >> 1;
    end
  end

  // Serialiser FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      tx_pin  <= 1'b1;
      cnt     <= '0;
      bit_idx <= '0;
    end else if (pop) begin
      state   <= START;
      tx_pin  <= 1'b0;
      cnt     <= '0;
      bit_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx_pin <= 1'b1;
        end
        START: begin
          if (bit_end) begin
            state  <= DATA;
            cnt    <= '0;
            tx_pin <= shreg[0];
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt <= '0;
            if (bit_idx == 4'(BIT - 1)) begin
`ifdef UART_TX_PARITY_EN
              state  <= PARITY;
              tx_pin <= par_q;
`else
              state  <= STOP;
              tx_pin <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
              // shreg shifts on this same edge, so [1] is the next bit
              tx_pin  <= shreg[1];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            state  <= STOP;
            cnt    <= '0;
            tx_pin <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          // A non-empty FIFO on the last stop cycle is taken by the pop branch
          if (stop_end) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          tx_pin <= 1'b1;
        end
      endcase
    end
  end

endmodule
